pio_bank_out: RTL

Multi-channel Avalon-MM output PIO bank, the parametrised successor of the single 32-bit output register. It holds N_CH output words of DATA_W bits, each with a shadow register and bit-set/bit-clear access. Outputs update either immediately (auto-commit) or together on a commit event from software or the external `commit_in` pin. Reads have one-cycle latency. It sits on the Nios system interconnect and drives motor/kicker set-point ports.

---
 rtl/pio_bank_out.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pio_bank_out.sv
// Multi-channel output PIO bank with per-channel shadow, bit set/clear and grouped commit.
// Writes act at the accepting edge, reads return one cycle later; always ready, no backpressure.
module pio_bank_out #(
  parameter int                DATA_W    = 32,
  parameter int                N_CH      = 4,
  parameter int                ADDR_W    = 5,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   chipselect,
  input  logic                   read_n,
  input  logic                   write_n,
  input  logic [DATA_W-1:0]      writedata,
  output logic [DATA_W-1:0]      readdata,
  input  logic                   commit_in,
  output logic [N_CH*DATA_W-1:0] out_port,
  output logic                   update
);

  localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(4 * N_CH);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(4 * N_CH + 1);

  logic [DATA_W-1:0] shadow_q [N_CH];
  logic [DATA_W-1:0] out_q    [N_CH];
  logic              auto_q;
  logic [N_CH-1:0]   pending_q;
  logic              sync1_q, sync2_q, sync3_q;

  logic              wr_en, rd_en, ch_hit;
  logic              sw_commit, ext_commit, commit;
  logic [1:0]        reg_sel;
  logic [ADDR_W-3:0] ch_sel;
  logic [N_CH-1:0]   ch_wr;
  logic [DATA_W-1:0] cur_shadow, cur_out, new_val, rd_val;

  assign reg_sel    = address[1:0];
  assign ch_sel     = address[ADDR_W-1:2];
  assign wr_en      = chipselect & ~write_n;
  assign rd_en      = chipselect & ~read_n;
  assign ch_hit     = address < CTRL_ADDR;
  assign sw_commit  = wr_en && (address == CTRL_ADDR) && writedata[1];
  // External edges only count in manual mode; the edge detector itself always runs.
  assign ext_commit = sync2_q & ~sync3_q & ~auto_q;
  assign commit     = sw_commit | ext_commit;

  always_comb begin
    cur_shadow = '0;
    cur_out    = '0;
    ch_wr      = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel == (ADDR_W-2)'(c)) begin
        cur_shadow = shadow_q[c];
        cur_out    = out_q[c];
        ch_wr[c]   = wr_en && ch_hit && (reg_sel != 2'd3);
      end
    end
    case (reg_sel)
      2'd1:    new_val = cur_shadow | writedata;
      2'd2:    new_val = cur_shadow & ~writedata;
      default: new_val = writedata;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (ch_hit) begin
      case (reg_sel)
        2'd0:    rd_val = cur_out;
        2'd3:    rd_val = cur_shadow;
        default: rd_val = '0;
      endcase
    end else if (address == CTRL_ADDR) begin
      rd_val = {{(DATA_W-1){1'b0}}, auto_q};
    end else if (address == STATUS_ADDR) begin
      rd_val = DATA_W'(pending_q);
    end
  end

  always_comb begin
    out_port = '0;
    for (int c = 0; c < N_CH; c++) begin
      out_port[c*DATA_W +: DATA_W] = out_q[c];
    end
  end

  // A channel write in the commit cycle overrides the commit for that channel's shadow/pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) begin
        shadow_q[c] <= RESET_VAL;
        out_q[c]    <= RESET_VAL;
      end
      pending_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (commit) begin
          out_q[c]     <= shadow_q[c];
          pending_q[c] <= 1'b0;
        end
        if (ch_wr[c]) begin
          shadow_q[c] <= new_val;
          if (auto_q) begin
            out_q[c]     <= new_val;
            pending_q[c] <= 1'b0;
          end else begin
            pending_q[c] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_q   <= 1'b1;
      update   <= 1'b0;
      readdata <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
    end else begin
      sync1_q <= commit_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      update  <= commit | ((|ch_wr) & auto_q);
      if (wr_en && (address == CTRL_ADDR)) begin
        auto_q <= writedata[0];
      end
      if (rd_en) begin
        readdata <= rd_val;
      end
    end
  end

endmodule
